piso_ser: RTL and testbench
===========================

// Module: piso_ser
// PURPOSE
//   Parallel-in serial-out serializer; upstream stage that drives the 4-bit siso chain's si input.
//   Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clock.
//   Qualifies each bit with so_valid and marks the frame's final bit with so_last.
//   Back-to-back words stream with zero idle cycles.
// PARAMETERS
//   WIDTH      4   data word width in bits; legal range 2..32
//   MSB_FIRST  1   1: emit din[WIDTH-1] first; 0: emit din[0] first
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-low (0 = reset)
//   shift_en   in   1      global advance enable; 0 freezes all state
//   din        in   WIDTH  parallel word
//   din_valid  in   1      din holds a word to send
//   din_ready  out  1      word accepted on edge where din_valid&din_ready&shift_en
//   so         out  1      serial data bit, registered; connects to siso si
//   so_valid   out  1      so carries a frame bit this cycle
//   so_last    out  1      so carries the final bit of the frame
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, shreg=0, cnt=0, so=0, so_valid=0, so_last=0.
//     A word in flight is discarded. din_ready=1 from the first cycle after release.
//   - States: IDLE, SHIFT, PARITY (PARITY exists only with PARITY_EN).
//   - din_ready is combinational: shift_en & (state==IDLE | so_last).
//   - Accept edge (din_valid&din_ready&shift_en):
//     - shreg<=din; so<=first bit; so_valid<=1; cnt<=1; state<=SHIFT.
//     - so_last<=0. WIDTH>=2, so the first bit is never last.
//   - Latency: first bit is on so the cycle after the accept edge.
//   - SHIFT, cnt<WIDTH:
//     - Each enabled edge: so<=next bit (order set by MSB_FIRST); cnt<=cnt+1.
//     - so_last<=(cnt==WIDTH-1) & !PARITY_EN.
//   - Last data bit on so, PARITY_EN defined: next edge so<=parity, so_last<=1, state<=PARITY.
//   - so_last=1 with a concurrent accept: next edge loads the new word as an accept edge.
//     No gap; so_valid stays 1.
//   - so_last=1, no accept: next edge so<=0, so_valid<=0, so_last<=0, state<=IDLE.
//   - shift_en=0: all registers hold, including so/so_valid/so_last; din_ready=0.
//     A bit on so is therefore held for multiple cycles.
//   - din is sampled only on the accept edge; din changes at other times are ignored.
//   - cnt width is clog2(WIDTH+1); cnt never wraps, because the frame ends at cnt==WIDTH.
// CONFIGURATION
//   PARITY_EN defined:
//     - Even parity bit (XOR of the accepted din, computed at accept) follows the data bits.
//     - Frame = WIDTH+1 bits; so_last marks the parity bit.
//     - din_ready is low during data bits and high during the parity bit.
//   PARITY_EN undefined:
//     - No PARITY state; frame = WIDTH bits; so_last marks the last data bit.
// TESTING
//   1. rst=0 mid-frame -> so=0, so_valid=0, so_last=0 immediately; after release din_ready=1.
//   2. WIDTH=4, MSB_FIRST=1, din=4'b1011 accepted:
//      -> so=1,0,1,1 on 4 consecutive cycles; so_last on the 4th; then so_valid=0.
//   3. Back-to-back 4'b1100 then 4'b0011 (din_valid held):
//      -> 8 contiguous valid bits 1,1,0,0,0,0,1,1; so_last on bits 4 and 8.
//   4. shift_en=0 for 2 cycles after bit 2 of 4'b1010:
//      -> so holds 0 for 3 cycles total; then 1,0; so_last on the final 0.
//   5. MSB_FIRST=0, din=4'b0001 -> so=1,0,0,0.
//   6. PARITY_EN, din=4'b0111 -> so=0,1,1,1,1; parity=1 with so_last=1.
//      din=4'b0110 -> parity bit 0.

Source files
------------

// File: rtl/piso_ser.sv
// Parallel-in serial-out serializer with valid/ready word input and valid/last bit output.
// Optional even-parity trailer bit enabled by defining PARITY_EN.
module piso_ser #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             so,
   output logic             so_valid,
   output logic             so_last,
   output logic [1:0]       o_dbg_state
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

   // Handshake: a word moves when din_valid & din_ready on an enabled rising edge;
   // din_ready already includes shift_en, so w_accept alone qualifies the transfer.
   state_t             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_shreg, w_shreg_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_so, w_so_nxt;
   logic               r_so_valid, w_so_valid_nxt;
   logic               r_so_last, w_so_last_nxt;
`ifdef PARITY_EN
   logic               r_parity, w_parity_nxt;
`endif
   logic [WIDTH-1:0]   w_shreg_sh;
   logic               w_first_bit;
   logic               w_next_bit;
   logic               w_accept;

   assign din_ready   = shift_en & ((r_state == S_IDLE) | r_so_last);
   assign w_accept    = din_valid & din_ready;
   assign w_shreg_sh  = (MSB_FIRST != 0) ? (r_shreg << 1) : (r_shreg >> 1);
   assign w_first_bit = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
   assign w_next_bit  = (MSB_FIRST != 0) ? w_shreg_sh[WIDTH-1] : w_shreg_sh[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_shreg    <= '0;
         r_cnt      <= '0;
         r_so       <= 1'b0;
         r_so_valid <= 1'b0;
         r_so_last  <= 1'b0;
`ifdef PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_shreg    <= w_shreg_nxt;
         r_cnt      <= w_cnt_nxt;
         r_so       <= w_so_nxt;
         r_so_valid <= w_so_valid_nxt;
         r_so_last  <= w_so_last_nxt;
`ifdef PARITY_EN
         r_parity   <= w_parity_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_shreg_nxt    = r_shreg;
      w_cnt_nxt      = r_cnt;
      w_so_nxt       = r_so;
      w_so_valid_nxt = r_so_valid;
      w_so_last_nxt  = r_so_last;
`ifdef PARITY_EN
      w_parity_nxt   = r_parity;
`endif
      if (w_accept) begin
         w_state_nxt    = S_SHIFT;
         w_shreg_nxt    = din;
         w_cnt_nxt      = CNT_W'(1);
         w_so_nxt       = w_first_bit;
         w_so_valid_nxt = 1'b1;
         w_so_last_nxt  = 1'b0;
`ifdef PARITY_EN
         w_parity_nxt   = ^din;
`endif
      end else if (shift_en) begin
         case (r_state)
            S_SHIFT: begin
               if (r_cnt < C_WIDTH) begin
                  w_shreg_nxt = w_shreg_sh;
                  w_cnt_nxt   = r_cnt + 1'b1;
                  w_so_nxt    = w_next_bit;
`ifdef PARITY_EN
                  w_so_last_nxt = 1'b0;
`else
                  w_so_last_nxt = (r_cnt == C_LAST);
`endif
               end else begin
`ifdef PARITY_EN
                  w_so_nxt      = r_parity;
                  w_so_last_nxt = 1'b1;
                  w_state_nxt   = S_PARITY;
`else
                  w_so_nxt       = 1'b0;
                  w_so_valid_nxt = 1'b0;
                  w_so_last_nxt  = 1'b0;
                  w_state_nxt    = S_IDLE;
`endif
               end
            end
            default: begin
               // Final bit shown and no new word: the frame ends and the line idles low.
               if (r_so_last) begin
                  w_so_nxt       = 1'b0;
                  w_so_valid_nxt = 1'b0;
                  w_so_last_nxt  = 1'b0;
                  w_state_nxt    = S_IDLE;
               end
            end
         endcase
      end
   end

   assign so          = r_so;
   assign so_valid    = r_so_valid;
   assign so_last     = r_so_last;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_piso_ser.sv
// Bench for piso_ser: directed vector table plus random traffic against a queue-based frame model.
// Two instances (MSB-first and LSB-first) share the same stimulus.
module tb_piso_ser;

   localparam int W = 4;
`ifdef PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         shift_en;
   logic         din_valid;
   logic [W-1:0] din;
   logic         a_rdy, a_so, a_v, a_l;
   logic         b_rdy, b_so, b_v, b_l;
   logic [1:0]   a_dbg, b_dbg;

   always #5 clk = ~clk;

   piso_ser #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .shift_en(shift_en), .din(din), .din_valid(din_valid),
      .din_ready(a_rdy), .so(a_so), .so_valid(a_v), .so_last(a_l), .o_dbg_state(a_dbg));

   piso_ser #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .shift_en(shift_en), .din(din), .din_valid(din_valid),
      .din_ready(b_rdy), .so(b_so), .so_valid(b_v), .so_last(b_l), .o_dbg_state(b_dbg));

   int n_chk  = 0;
   int n_fail = 0;

   // Each entry is {last, bit} of a frame bit still to appear on so; entry 0 is on so now.
   logic [1:0] exp_msb_q[$];
   logic [1:0] exp_lsb_q[$];

   typedef struct {
      logic         sh;
      logic         vld;
      logic [W-1:0] d;
      logic         e_so_m;
      logic         e_so_l;
      logic         e_v;
      logic         e_l;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic sh, input logic vld, input logic [W-1:0] d,
                      input logic em, input logic el, input logic ev, input logic elst);
      vec_t v;
      v.sh = sh; v.vld = vld; v.d = d;
      v.e_so_m = em; v.e_so_l = el; v.e_v = ev; v.e_l = elst;
      vecs.push_back(v);
   endtask

   task automatic load_model(input logic [W-1:0] d);
      exp_msb_q.delete();
      exp_lsb_q.delete();
      for (int i = 0; i < W; i++) begin
         exp_msb_q.push_back({(i == W - 1) && !PAR, d[W-1-i]});
         exp_lsb_q.push_back({(i == W - 1) && !PAR, d[i]});
      end
      if (PAR) begin
         exp_msb_q.push_back({1'b1, ^d});
         exp_lsb_q.push_back({1'b1, ^d});
      end
   endtask

   task automatic cycle(input logic sh, input logic vld, input logic [W-1:0] d,
                        input bit tab, input logic em, input logic el, input logic ev,
                        input logic elst);
      logic       m_rdy;
      logic [1:0] fm, fl;
      @(negedge clk);
      shift_en  = sh;
      din_valid = vld;
      din       = d;
      #1;
      fm    = (exp_msb_q.size() > 0) ? exp_msb_q[0] : 2'b00;
      fl    = (exp_lsb_q.size() > 0) ? exp_lsb_q[0] : 2'b00;
      m_rdy = sh & ((exp_msb_q.size() == 0) | fm[1]);
      chk("msb_so",    a_so,  fm[0]);
      chk("msb_valid", a_v,   exp_msb_q.size() > 0);
      chk("msb_last",  a_l,   fm[1]);
      chk("msb_ready", a_rdy, m_rdy);
      chk("lsb_so",    b_so,  fl[0]);
      chk("lsb_valid", b_v,   exp_lsb_q.size() > 0);
      chk("lsb_last",  b_l,   fl[1]);
      chk("lsb_ready", b_rdy, m_rdy);
      if (tab) begin
         chk("tab_msb_so", a_so, em);
         chk("tab_lsb_so", b_so, el);
         chk("tab_valid",  a_v,  ev);
         chk("tab_last",   a_l,  elst);
      end
      @(posedge clk);
      if (sh) begin
         if (vld && m_rdy) load_model(d);
         else if (exp_msb_q.size() > 0) begin
            void'(exp_msb_q.pop_front());
            void'(exp_lsb_q.pop_front());
         end
      end
   endtask

   initial begin
`ifdef PARITY_EN
      add(1, 1, 4'b0111, 0, 0, 0, 0);
      add(1, 0, 4'b0000, 0, 1, 1, 0);
      add(1, 0, 4'b0000, 1, 1, 1, 0);
      add(1, 0, 4'b0000, 1, 1, 1, 0);
      add(1, 0, 4'b0000, 1, 0, 1, 0);
      add(1, 1, 4'b0110, 1, 1, 1, 1);
      add(1, 0, 4'b0000, 0, 0, 1, 0);
      add(1, 0, 4'b0000, 1, 1, 1, 0);
      add(1, 0, 4'b0000, 1, 1, 1, 0);
      add(1, 0, 4'b0000, 0, 0, 1, 0);
      add(1, 0, 4'b0000, 0, 0, 1, 1);
      add(1, 0, 4'b0000, 0, 0, 0, 0);
`else
      add(1, 1, 4'b1011, 0, 0, 0, 0);
      add(1, 0, 4'b0000, 1, 1, 1, 0);
      add(1, 0, 4'b0000, 0, 1, 1, 0);
      add(1, 0, 4'b0000, 1, 0, 1, 0);
      add(1, 0, 4'b0000, 1, 1, 1, 1);
      add(1, 0, 4'b0000, 0, 0, 0, 0);
      add(1, 1, 4'b1100, 0, 0, 0, 0);
      add(1, 1, 4'b0011, 1, 0, 1, 0);
      add(1, 1, 4'b0011, 1, 0, 1, 0);
      add(1, 1, 4'b0011, 0, 1, 1, 0);
      add(1, 1, 4'b0011, 0, 1, 1, 1);
      add(1, 0, 4'b0000, 0, 1, 1, 0);
      add(1, 0, 4'b0000, 0, 1, 1, 0);
      add(1, 0, 4'b0000, 1, 0, 1, 0);
      add(1, 0, 4'b0000, 1, 0, 1, 1);
      add(1, 0, 4'b0000, 0, 0, 0, 0);
      add(1, 1, 4'b1010, 0, 0, 0, 0);
      add(1, 0, 4'b0000, 1, 0, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 0);
      add(0, 0, 4'b0000, 0, 1, 1, 0);
      add(1, 0, 4'b0000, 0, 1, 1, 0);
      add(1, 0, 4'b0000, 1, 0, 1, 0);
      add(1, 0, 4'b0000, 0, 1, 1, 1);
      add(1, 0, 4'b0000, 0, 0, 0, 0);
      add(1, 1, 4'b0001, 0, 0, 0, 0);
      add(1, 0, 4'b0000, 0, 1, 1, 0);
      add(1, 0, 4'b0000, 0, 0, 1, 0);
      add(1, 0, 4'b0000, 0, 0, 1, 0);
      add(1, 0, 4'b0000, 1, 0, 1, 1);
      add(1, 0, 4'b0000, 0, 0, 0, 0);
`endif

      rst = 1'b0; shift_en = 1'b1; din_valid = 1'b0; din = '0;
      repeat (2) @(negedge clk);
      chk("rst_so",    a_so, 0);
      chk("rst_valid", a_v,  0);
      chk("rst_last",  b_l,  0);
      rst = 1'b1;

      foreach (vecs[i])
         cycle(vecs[i].sh, vecs[i].vld, vecs[i].d, 1'b1,
               vecs[i].e_so_m, vecs[i].e_so_l, vecs[i].e_v, vecs[i].e_l);

      // Asynchronous reset in the middle of a frame clears the outputs without a clock edge.
      cycle(1, 1, 4'b1111, 0, 0, 0, 0, 0);
      cycle(1, 0, 4'b0000, 0, 0, 0, 0, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_msb_so",    a_so, 0);
      chk("arst_msb_valid", a_v,  0);
      chk("arst_msb_last",  a_l,  0);
      chk("arst_lsb_so",    b_so, 0);
      chk("arst_lsb_valid", b_v,  0);
      exp_msb_q.delete();
      exp_lsb_q.delete();
      @(negedge clk);
      rst = 1'b1;

      for (int n = 0; n < 800; n++)
         cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
               W'($urandom_range(0, (1 << W) - 1)), 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
